// File: rtl/bm_pkg.sv
// Shared types for the block-matching scan sequencer: FSM states, the packed
// {dy,dx} candidate word and the coordinate value reported on a drain timeout.
package bm_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} scan_state_t;

    typedef struct packed {
        logic [7:0] dy;
        logic [7:0] dx;
    } coord_t;

    localparam logic [15:0] COORD_INVALID = 16'hFFFF;

endpackage

// File: rtl/scan_offset_counter.sv
// Nested dy/dx offset counter: dy ascends in the outer loop, dx descends from
// DX_MAX to 0 in the inner loop. last flags the final offset {DY_MAX,0}.
module scan_offset_counter
    import bm_pkg::*;
#(
    parameter int DY_MAX = 7,
    parameter int DX_MAX = 47
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        advance,
    output logic [15:0] coords,
    output logic        last
);

    localparam int DY_W = $clog2(DY_MAX + 1);
    localparam int DX_W = $clog2(DX_MAX + 1);

    logic [DY_W-1:0] dy_reg;
    logic [DX_W-1:0] dx_reg;
    coord_t          pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dy_reg <= '0;
            dx_reg <= '0;
        end else if (clear) begin
            dy_reg <= '0;
            dx_reg <= DX_W'(DX_MAX);
        end else if (advance) begin
            if (dx_reg == '0) begin
                dx_reg <= DX_W'(DX_MAX);
                dy_reg <= (dy_reg == DY_W'(DY_MAX)) ? '0 : dy_reg + 1'b1;
            end else begin
                dx_reg <= dx_reg - 1'b1;
            end
        end
    end

    always_comb begin
        pos.dy = 8'(dy_reg);
        pos.dx = 8'(dx_reg);
    end

    assign coords = pos;
    assign last   = (dy_reg == DY_W'(DY_MAX)) && (dx_reg == '0);

endmodule

// File: rtl/block_scan_sequencer.sv
// Block-matching sequencer: accepts a job, streams every search offset to the
// SAD engine, waits for the finder result (or times out) and presents it.
// Optional performance counters are built when SCAN_PERF_EN is defined.
module block_scan_sequencer
    import bm_pkg::*;
#(
    parameter int BLK_W    = 16,
    parameter int BLK_H    = 16,
    parameter int SEARCH_W = 64,
    parameter int SEARCH_H = 24,
    parameter int DRAIN_TO = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        blk_valid,
    input  logic [15:0] blk_index,
    output logic        blk_ready,
    output logic        cand_valid,
    output logic [15:0] cand_coords,
    output logic [15:0] cand_blk_index,
    input  logic        cand_ready,
    input  logic        res_valid,
    input  logic [15:0] res_coords,
    output logic        out_valid,
    output logic [15:0] out_blk_index,
    output logic [15:0] out_coords,
    output logic        out_timeout,
    input  logic        out_ready,
    output logic        err_spurious
`ifdef SCAN_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_blk_cycles
`endif
);

    localparam int DX_MAX = SEARCH_W - BLK_W - 1;
    localparam int DY_MAX = SEARCH_H - BLK_H - 1;

    scan_state_t state_reg;
    logic        blk_ready_reg;
    logic [7:0]  timer_reg;
    logic        accept;
    logic        advance;
    logic        last;

    // A job may be taken in the same cycle the previous result is handed off.
    assign blk_ready = blk_ready_reg || (out_valid && out_ready);
    assign accept    = blk_valid && blk_ready;
    assign advance   = (state_reg == SCAN) && cand_valid && cand_ready;

    scan_offset_counter #(
        .DY_MAX (DY_MAX),
        .DX_MAX (DX_MAX)
    ) u_offset (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .advance (advance),
        .coords  (cand_coords),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            blk_ready_reg  <= 1'b1;
            cand_valid     <= 1'b0;
            cand_blk_index <= '0;
            timer_reg      <= '0;
            out_valid      <= 1'b0;
            out_blk_index  <= '0;
            out_coords     <= '0;
            out_timeout    <= 1'b0;
            err_spurious   <= 1'b0;
        end else begin
            if (res_valid && (state_reg != DRAIN))
                err_spurious <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cand_blk_index <= blk_index;
                        cand_valid     <= 1'b1;
                        blk_ready_reg  <= 1'b0;
                        state_reg      <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance && last) begin
                        cand_valid <= 1'b0;
                        timer_reg  <= '0;
                        state_reg  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A result arriving on the timeout cycle still takes priority.
                    if (res_valid) begin
                        out_valid     <= 1'b1;
                        out_coords    <= res_coords;
                        out_timeout   <= 1'b0;
                        out_blk_index <= cand_blk_index;
                        state_reg     <= OUT;
                    end else if (timer_reg == 8'(DRAIN_TO - 1)) begin
                        out_valid     <= 1'b1;
                        out_coords    <= COORD_INVALID;
                        out_timeout   <= 1'b1;
                        out_blk_index <= cand_blk_index;
                        state_reg     <= OUT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (blk_valid) begin
                            cand_blk_index <= blk_index;
                            cand_valid     <= 1'b1;
                            state_reg      <= SCAN;
                        end else begin
                            blk_ready_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SCAN_PERF_EN
    logic [15:0] blk_cyc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt  <= '0;
            perf_blk_cycles <= '0;
            blk_cyc_reg     <= '0;
        end else begin
            if ((state_reg == SCAN) && !cand_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (out_valid && out_ready)
                perf_blk_cycles <= blk_cyc_reg;
            if (accept)
                blk_cyc_reg <= 16'd1;
            else if (blk_cyc_reg != '1)
                blk_cyc_reg <= blk_cyc_reg + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_block_scan_sequencer.sv
// Directed-random bench for block_scan_sequencer with an offset-order model
// built from the scan rules and per-job result expectations.
module tb_block_scan_sequencer;

    localparam int DRAIN_TO = 255;
    localparam int NCAND    = 384;

    logic        clk;
    logic        reset_n;
    logic        blk_valid;
    logic [15:0] blk_index;
    logic        blk_ready;
    logic        cand_valid;
    logic [15:0] cand_coords;
    logic [15:0] cand_blk_index;
    logic        cand_ready;
    logic        res_valid;
    logic [15:0] res_coords;
    logic        out_valid;
    logic [15:0] out_blk_index;
    logic [15:0] out_coords;
    logic        out_timeout;
    logic        out_ready;
    logic        err_spurious;

    int          total;
    int          bad;
    logic [15:0] exp_q[$];
    logic [15:0] first_obs;
    logic [15:0] last_obs;

    block_scan_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .blk_valid      (blk_valid),
        .blk_index      (blk_index),
        .blk_ready      (blk_ready),
        .cand_valid     (cand_valid),
        .cand_coords    (cand_coords),
        .cand_blk_index (cand_blk_index),
        .cand_ready     (cand_ready),
        .res_valid      (res_valid),
        .res_coords     (res_coords),
        .out_valid      (out_valid),
        .out_blk_index  (out_blk_index),
        .out_coords     (out_coords),
        .out_timeout    (out_timeout),
        .out_ready      (out_ready),
        .err_spurious   (err_spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic offer_job(input logic [15:0] idx);
        blk_valid = 1'b1;
        blk_index = idx;
        #1 check("job_ready", blk_ready, 1'b1);
        @(negedge clk);
        blk_valid = 1'b0;
        check("job_cand_valid", cand_valid, 1'b1);
        check("job_busy", blk_ready, 1'b0);
        check("job_index", cand_blk_index, idx);
        $display("job accepted idx=%h", idx);
    endtask

    task automatic do_scan(input logic [15:0] idx, input int stall_pct, input int spur_at);
        int          n = 0;
        int          errs = 0;
        int          stab = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [15:0] held = '0;
        while (n < NCAND && cyc < 20000) begin
            res_valid = (cyc == spur_at);
            if (!cand_valid) begin
                errs++;
                cyc = 20000;
            end else begin
                if (stalled && (cand_coords !== held || cand_blk_index !== idx))
                    stab++;
                cand_ready = ($urandom_range(99) >= stall_pct);
                if (cand_ready) begin
                    if (cand_coords !== exp_q[n]) errs++;
                    if (n == 0) first_obs = cand_coords;
                    last_obs = cand_coords;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = cand_coords;
                end
                @(negedge clk);
                cyc++;
            end
        end
        res_valid  = 1'b0;
        cand_ready = 1'b0;
        check("scan_count", n, NCAND);
        check("scan_order_errs", errs, 0);
        check("scan_stall_stable_errs", stab, 0);
        check("scan_first", first_obs, 16'h002F);
        check("scan_last", last_obs, 16'h0700);
        check("cand_drop", cand_valid, 1'b0);
        $display("scan done idx=%h cands=%0d stall_pct=%0d", idx, n, stall_pct);
    endtask

    task automatic do_drain(input int delay, input logic [15:0] rc);
        int cnt = 0;
        if (delay > 0) begin
            repeat (delay - 1) @(negedge clk);
            res_valid  = 1'b1;
            res_coords = rc;
            @(negedge clk);
            res_valid = 1'b0;
            check("res_out_valid", out_valid, 1'b1);
        end else begin
            while (!out_valid && cnt < 1000) begin
                @(negedge clk);
                cnt++;
            end
            check("timeout_cycles", cnt, DRAIN_TO);
        end
        $display("drain done delay=%0d", delay);
    endtask

    task automatic finish_out(input logic [15:0] idx, input logic [15:0] ec, input logic eto,
                              input int hold, input logic pre, input logic [15:0] nidx);
        int errs = 0;
        check("out_valid", out_valid, 1'b1);
        check("out_blk_index", out_blk_index, idx);
        check("out_coords", out_coords, ec);
        check("out_timeout", out_timeout, eto);
        out_ready = 1'b0;
        if (pre) begin
            blk_valid = 1'b1;
            blk_index = nidx;
        end
        repeat (hold) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_coords !== ec || out_blk_index !== idx ||
                out_timeout !== eto || cand_valid !== 1'b0)
                errs++;
        end
        if (hold > 0) check("out_hold_errs", errs, 0);
        out_ready = 1'b1;
        #1 check("ready_in_handshake", blk_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        blk_valid = 1'b0;
        check("out_released", out_valid, 1'b0);
        if (pre) begin
            check("zero_bubble_cand_valid", cand_valid, 1'b1);
            check("zero_bubble_index", cand_blk_index, nidx);
            check("zero_bubble_busy", blk_ready, 1'b0);
        end else begin
            check("idle_ready", blk_ready, 1'b1);
        end
        $display("result idx=%h coords=%h timeout=%0d hold=%0d", idx, ec, eto, hold);
    endtask

    initial begin
        logic [15:0] idx;
        logic [15:0] idx2;
        logic [15:0] rc;
        total = 0;
        bad   = 0;
        for (int dy = 0; dy <= 7; dy++)
            for (int dx = 47; dx >= 0; dx--)
                exp_q.push_back({dy[7:0], dx[7:0]});

        reset_n    = 1'b0;
        blk_valid  = 1'b0;
        blk_index  = '0;
        cand_ready = 1'b0;
        res_valid  = 1'b0;
        res_coords = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_blk_ready", blk_ready, 1'b1);
        check("rst_cand_valid", cand_valid, 1'b0);
        check("rst_cand_coords", cand_coords, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_coords", out_coords, 16'h0000);
        check("rst_out_timeout", out_timeout, 1'b0);
        check("rst_err", err_spurious, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Job 1: no backpressure, result three cycles after the last candidate.
        idx = 16'($urandom); rc = 16'($urandom);
        offer_job(idx);
        do_scan(idx, 0, -1);
        do_drain(3, rc);
        finish_out(idx, rc, 1'b0, 0, 1'b0, 16'h0);

        // Job 2: 50% backpressure.
        idx = 16'($urandom); rc = 16'($urandom);
        offer_job(idx);
        do_scan(idx, 50, -1);
        do_drain(int'($urandom_range(20, 1)), rc);
        finish_out(idx, rc, 1'b0, 0, 1'b0, 16'h0);

        // Job 3: finder never answers.
        idx = 16'($urandom);
        offer_job(idx);
        do_scan(idx, 30, -1);
        do_drain(0, 16'h0);
        finish_out(idx, 16'hFFFF, 1'b1, 0, 1'b0, 16'h0);
        check("no_spurious_yet", err_spurious, 1'b0);

        // Job 4: stray result during SCAN; real result on the timeout cycle.
        idx = 16'($urandom); rc = 16'($urandom_range(16'hFFFE));
        offer_job(idx);
        do_scan(idx, 0, 100);
        check("spurious_set", err_spurious, 1'b1);
        do_drain(DRAIN_TO, rc);
        finish_out(idx, rc, 1'b0, 0, 1'b0, 16'h0);
        check("spurious_sticky", err_spurious, 1'b1);

        // Jobs 5/6: held result, next job pre-asserted and taken at handshake.
        idx = 16'($urandom); rc = 16'($urandom); idx2 = 16'($urandom);
        offer_job(idx);
        do_scan(idx, 20, -1);
        do_drain(5, rc);
        finish_out(idx, rc, 1'b0, 10, 1'b1, idx2);
        rc = 16'($urandom);
        do_scan(idx2, 20, -1);
        do_drain(2, rc);
        finish_out(idx2, rc, 1'b0, 0, 1'b0, 16'h0);

        // Job 7: asynchronous reset mid-scan, then a fresh job.
        idx = 16'($urandom);
        offer_job(idx);
        cand_ready = 1'b1;
        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_cand_valid", cand_valid, 1'b0);
        check("arst_blk_ready", blk_ready, 1'b1);
        check("arst_cand_coords", cand_coords, 16'h0000);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_err", err_spurious, 1'b0);
        $display("async reset applied mid-scan");
        cand_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        idx = 16'($urandom); rc = 16'($urandom);
        offer_job(idx);
        do_scan(idx, 40, -1);
        do_drain(2, rc);
        finish_out(idx, rc, 1'b0, 0, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
